// File: rtl/conv_sum_accum.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | conv_sum_accum: row-sum / pixel accumulator with pixel FIFO and 2-phase  |
// | req/ack on both sides. Optional macro SUM_SAT_EN selects saturation.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_sum_accum #(
  parameter int LANES     = 5,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8,
  parameter int ROWS      = 5,
  parameter int DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        aReq,
  output logic                        aAck,
  input  logic [LANES*WIDTH_IN-1:0]   data_in,
  output logic                        bReq,
  input  logic                        bAck,
  output logic [WIDTH_OUT-1:0]        data_out,
  output logic [$clog2(ROWS+1)-1:0]   row_idx,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  localparam int RS_W   = WIDTH_IN + $clog2(LANES);
  localparam int ACC_W  = RS_W + $clog2(ROWS);
  localparam int RIDX_W = $clog2(ROWS + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
`ifdef SUM_SAT_EN
  localparam logic [ACC_W-1:0]  PIX_MAX  = ACC_W'({WIDTH_OUT{1'b1}});
`endif

  logic                 a_ack_q, a_ack_d;
  logic                 b_req_q, b_req_d;
  logic [WIDTH_OUT-1:0] data_out_q, data_out_d;
  logic [RIDX_W-1:0]    row_idx_q, row_idx_d;
  logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WIDTH_OUT-1:0] mem_q [DEPTH];
  logic [WIDTH_OUT-1:0] mem_d [DEPTH];

  logic                 token_pending, last_row, stall, accept, push, out_idle, pop;
  logic [RS_W-1:0]      row_sum;
  logic [ACC_W-1:0]     sum_total;
  logic [WIDTH_OUT-1:0] pixel;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Stall looks only at the registered count, so a pop on the same edge
  // cannot let a last row in.
  assign token_pending = aReq ^ a_ack_q;
  assign last_row      = (row_idx_q == LAST_ROW);
  assign stall         = last_row && (fifo_count_q == FULL_CNT);
  assign accept        = token_pending && !stall;
  assign push          = accept && last_row;
  assign out_idle      = (b_req_q == bAck);
  assign pop           = out_idle && (fifo_count_q != '0);

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      row_sum = row_sum + RS_W'(data_in[i*WIDTH_IN +: WIDTH_IN]);
    end
    sum_total = acc_q + ACC_W'(row_sum);
`ifdef SUM_SAT_EN
    pixel = (sum_total > PIX_MAX) ? '1 : WIDTH_OUT'(sum_total);
`else
    pixel = WIDTH_OUT'(sum_total);
`endif
  end

  always_comb begin
    a_ack_d      = a_ack_q;
    b_req_d      = b_req_q;
    data_out_d   = data_out_q;
    row_idx_d    = row_idx_q;
    fifo_count_d = fifo_count_q;
    acc_d        = acc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;

    if (accept) begin
      a_ack_d = aReq;
      if (last_row) begin
        acc_d     = '0;
        row_idx_d = '0;
      end else begin
        acc_d     = sum_total;
        row_idx_d = row_idx_q + RIDX_W'(1);
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = pixel;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end

    if (pop) begin
      data_out_d = mem_q[rd_ptr_q];
      b_req_d    = ~b_req_q;
      rd_ptr_d   = ptr_next(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_ack_q      <= 1'b0;
      b_req_q      <= 1'b0;
      data_out_q   <= '0;
      row_idx_q    <= '0;
      fifo_count_q <= '0;
      acc_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      a_ack_q      <= a_ack_d;
      b_req_q      <= b_req_d;
      data_out_q   <= data_out_d;
      row_idx_q    <= row_idx_d;
      fifo_count_q <= fifo_count_d;
      acc_q        <= acc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign aAck       = a_ack_q;
  assign bReq       = b_req_q;
  assign data_out   = data_out_q;
  assign row_idx    = row_idx_q;
  assign fifo_count = fifo_count_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_sum_accum.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for conv_sum_accum: cycle model with a pixel queue plus directed scenarios.
module tb_conv_sum_accum;
  localparam int LANES = 5;
  localparam int ROWS  = 5;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        aReq = 1'b0;
  logic        bAck = 1'b0;
  logic [39:0] data_in = '0;
  logic        aAck, bReq;
  logic [7:0]  data_out;
  logic [2:0]  row_idx;
  logic [1:0]  fifo_count;

  logic        aReq6 = 1'b0;
  logic        bAck6 = 1'b0;
  logic [11:0] data_in6 = '0;
  logic        aAck6, bReq6;
  logic [7:0]  data_out6;
  logic [0:0]  row_idx6;
  logic [1:0]  fifo_count6;

  conv_sum_accum dut (
    .clk(clk), .reset(reset), .aReq(aReq), .aAck(aAck), .data_in(data_in),
    .bReq(bReq), .bAck(bAck), .data_out(data_out), .row_idx(row_idx),
    .fifo_count(fifo_count)
  );

  conv_sum_accum #(.LANES(3), .WIDTH_IN(4), .WIDTH_OUT(8), .ROWS(1), .DEPTH(2)) dut6 (
    .clk(clk), .reset(reset), .aReq(aReq6), .aAck(aAck6), .data_in(data_in6),
    .bReq(bReq6), .bAck(bAck6), .data_out(data_out6), .row_idx(row_idx6),
    .fifo_count(fifo_count6)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fin(input int x);
`ifdef SUM_SAT_EN
    return (x > 255) ? 255 : x;
`else
    return x % 256;
`endif
  endfunction

  // Reference model: pixels are plain integers in a queue of at most DEPTH.
  bit m_valid = 0;
  bit m_aack, m_breq;
  int m_dout, m_row, m_acc;
  int m_q[$];

  always @(posedge clk) begin
    int rs, sum;
    bit last, acc_ok, do_pop;
    if (!reset) begin
      m_aack = 0; m_breq = 0; m_dout = 0; m_row = 0; m_acc = 0;
      m_q.delete();
      m_valid = 1;
    end else if (m_valid) begin
      rs = 0;
      for (int i = 0; i < LANES; i++) rs += int'(data_in[i*8 +: 8]);
      last   = (m_row == ROWS - 1);
      acc_ok = (aReq != m_aack) && !(last && m_q.size() == DEPTH);
      do_pop = (m_breq == bAck) && (m_q.size() > 0);
      if (do_pop) begin
        m_dout = m_q.pop_front();
        m_breq = ~m_breq;
      end
      if (acc_ok) begin
        m_aack = aReq;
        sum = m_acc + rs;
        if (last) begin
          m_q.push_back(fin(sum));
          m_acc = 0;
          m_row = 0;
        end else begin
          m_acc = sum;
          m_row++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("aAck", 64'(aAck), 64'(m_aack));
      chk("bReq", 64'(bReq), 64'(m_breq));
      chk("data_out", 64'(data_out), 64'(m_dout));
      chk("row_idx", 64'(row_idx), 64'(m_row));
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    end
  end

  int   cyc = 0, a_tog = 0, b_tog = 0, a_cyc = 0, b_cyc = 0;
  logic p_a = 1'bx, p_b = 1'bx;
  always @(negedge clk) begin
    cyc++;
    if (aAck !== p_a) begin a_tog++; a_cyc = cyc; end
    if (bReq !== p_b) begin b_tog++; b_cyc = cyc; end
    p_a = aAck;
    p_b = bReq;
  end

  bit sink_en = 0;
  int sink_div = 3;
  int got[$];

  task automatic consume();
    got.push_back(int'(data_out));
    bAck = ~bAck;
  endtask

  initial forever begin
    @(posedge clk);
    #3;
    if (sink_en && (bReq != bAck) && ($urandom_range(0, sink_div - 1) == 0)) consume();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_a_idle();
    int n = 0;
    while (aReq != aAck && n < 400) begin step(); n++; end
    chk("input_handshake_timeout", 64'(aReq != aAck), 64'(0));
  endtask

  task automatic send_token(input logic [39:0] d);
    wait_a_idle();
    data_in = d;
    aReq = ~aReq;
  endtask

  task automatic send_frame(input logic [7:0] v);
    repeat (ROWS) send_token({5{v}});
  endtask

  task automatic drain();
    int n = 0;
    while (!(m_q.size() == 0 && bReq == bAck && aReq == aAck) && n < 2000) begin
      step(); n++;
    end
    chk("drain_timeout", 64'(n >= 2000), 64'(0));
  endtask

  initial begin
    int a0, b0, n, exp6;
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0, n, exp6;
    logic [11:0] t6 [3];
    step(); step();
    reset = 1'b1;
    chk("reset_aAck", 64'(aAck), 0);
    chk("reset_bReq", 64'(bReq), 0);
    chk("reset_data_out", 64'(data_out), 0);
    chk("reset_row_idx", 64'(row_idx), 0);
    chk("reset_fifo_count", 64'(fifo_count), 0);

    // T1
    sink_en = 1;
    a0 = a_tog; b0 = b_tog;
    send_frame(8'h01);
    drain();
    chk("t1_ack_toggles", 64'(a_tog - a0), 5);
    chk("t1_req_toggles", 64'(b_tog - b0), 1);
    chk("t1_latency", 64'(b_cyc - a_cyc), 1);
    chk("t1_data_out", 64'(data_out), 25);
    chk("t1_row_idx", 64'(row_idx), 0);

    // T2
    send_frame(8'hFF);
    drain();
`ifdef SUM_SAT_EN
    chk("t2_data_out", 64'(data_out), 64'h0FF);
`else
    chk("t2_data_out", 64'(data_out), 64'h0E7);
`endif

    // T3: sink holds bAck, FIFO fills, last row of frame 4 stalls
    sink_en = 0;
    got.delete();
    repeat (19) send_token({5{8'h01}});
    send_token({5{8'h01}});
    repeat (10) step();
    chk("t3_fifo_count", 64'(fifo_count), 2);
    chk("t3_20th_pending", 64'(aReq != aAck), 1);
    chk("t3_row_idx", 64'(row_idx), 4);
    chk("t3_data_out", 64'(data_out), 25);
    consume();
    step();
    chk("t3_no_ack_on_pop_edge", 64'(aReq != aAck), 1);
    chk("t3_new_pixel_out", 64'(bReq != bAck), 1);
    step();
    chk("t3_ack_after_pop", 64'(aReq == aAck), 1);
    sink_en = 1;
    drain();
    chk("t3_pixel_count", 64'(got.size()), 4);
    for (int i = 0; i < got.size(); i++) chk("t3_pixel_value", 64'(got[i]), 25);

    // T4: reset mid-frame
    sink_en = 0;
    repeat (3) send_token({5{8'h02}});
    wait_a_idle();
    reset = 1'b0; aReq = 1'b0; bAck = 1'b0;
    step();
    chk("t4_aAck", 64'(aAck), 0);
    chk("t4_bReq", 64'(bReq), 0);
    chk("t4_data_out", 64'(data_out), 0);
    chk("t4_row_idx", 64'(row_idx), 0);
    chk("t4_fifo_count", 64'(fifo_count), 0);
    reset = 1'b1;
    sink_en = 1;
    send_frame(8'h01);
    drain();
    chk("t4_data_out_after", 64'(data_out), 25);

    // T5: push and pop on the same edge
    sink_en = 0;
    got.delete();
    send_frame(8'h01);
    send_frame(8'h02);
    repeat (4) send_token({5{8'h03}});
    wait_a_idle();
    step();
    chk("t5_fifo_before", 64'(fifo_count), 1);
    data_in = {5{8'h03}};
    aReq = ~aReq;
    consume();
    step();
    chk("t5_fifo_same_edge", 64'(fifo_count), 1);
    chk("t5_last_row_acked", 64'(aReq == aAck), 1);
    sink_en = 1;
    drain();
    chk("t5_pixel_count", 64'(got.size()), 3);
    if (got.size() == 3) begin
      chk("t5_pixel0", 64'(got[0]), 25);
      chk("t5_pixel1", 64'(got[1]), 50);
      chk("t5_pixel2", 64'(got[2]), 75);
    end

    // Randomized traffic with varying sink speed
    for (int k = 0; k < 300; k++) begin
      sink_div = (k < 150) ? 2 : 16;
      repeat ($urandom_range(0, 3)) step();
      send_token({8'($urandom), 32'($urandom)});
    end
    sink_div = 2;
    drain();

    // T6: ROWS=1, LANES=3, WIDTH_IN=4 instance
    t6[0] = {4'h2, 4'h1, 4'hF};
    t6[1] = {4'hF, 4'hF, 4'hF};
    t6[2] = {4'h1, 4'h0, 4'h0};
    for (int k = 0; k < 3; k++) begin
      exp6 = int'(t6[k][3:0]) + int'(t6[k][7:4]) + int'(t6[k][11:8]);
      data_in6 = t6[k];
      aReq6 = ~aReq6;
      n = 0;
      while (bReq6 == bAck6 && n < 50) begin step(); n++; end
      chk("t6_req_toggle", 64'(bReq6 != bAck6), 1);
      chk("t6_acked", 64'(aReq6 == aAck6), 1);
      chk("t6_data_out", 64'(data_out6), 64'(exp6));
      bAck6 = ~bAck6;
      step();
    end
    chk("t6_first_pixel_literal", 64'(int'(t6[0][3:0]) + int'(t6[0][7:4]) + int'(t6[0][11:8])), 18);
    step();
    chk("t6_fifo_empty", 64'(fifo_count6), 0);
    chk("t6_output_idle", 64'(bReq6 == bAck6), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
